// File: rtl/ppm_shift_two.sv
// 4-PPM modulator: splits each buffered byte into four 2-bit symbols (MSB pair first)
// and places one pulse per symbol in one of four slots, plus optional guard slots.
module ppm_shift_two #(
  parameter int SLOT_CYCLES = 4,
  parameter int GUARD_SLOTS = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       strobe,
  input  logic [7:0] data_in,
  output logic       data_send_done,
  output logic       ppm_out,
  output logic       busy,
  output logic       sym_start
);

  localparam logic [7:0] CYC_LAST  = 8'(SLOT_CYCLES - 1);
  localparam logic [4:0] SLOT_LAST = 5'(3 + GUARD_SLOTS);

  typedef enum logic [1:0] {IDLE, LOAD, SYMBOL, SETTLE} state_t;

  state_t     state, state_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [1:0] sym_cnt, sym_nxt;
  logic [4:0] slot_cnt, slot_nxt;
  logic [7:0] cyc_cnt, cyc_nxt;
  logic       settle_cnt, settle_nxt;
  logic       ppm_nxt, done_nxt, busy_nxt, start_nxt;

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    sym_nxt    = sym_cnt;
    slot_nxt   = slot_cnt;
    cyc_nxt    = cyc_cnt;
    settle_nxt = settle_cnt;
    case (state)
      IDLE: begin
        if (strobe) state_nxt = LOAD;
      end
      LOAD: begin
        if (strobe) begin
          shreg_nxt = data_in;
          sym_nxt   = 2'd0;
          slot_nxt  = 5'd0;
          cyc_nxt   = 8'd0;
          state_nxt = SYMBOL;
        end else begin
          state_nxt = IDLE;
        end
      end
      SYMBOL: begin
        if (cyc_cnt == CYC_LAST) begin
          cyc_nxt = 8'd0;
          if (slot_cnt == SLOT_LAST) begin
            slot_nxt  = 5'd0;
            shreg_nxt = {shreg[5:0], 2'b00};
            sym_nxt   = sym_cnt + 2'd1;
            if (sym_cnt == 2'd3) begin
              state_nxt  = SETTLE;
              settle_nxt = 1'b0;
            end
          end else begin
            slot_nxt = slot_cnt + 5'd1;
          end
        end else begin
          cyc_nxt = cyc_cnt + 8'd1;
        end
      end
      SETTLE: begin
        // Two cycles let the buffer decrement and re-register data_out before LOAD samples it.
        if (settle_cnt) state_nxt = LOAD;
        else            settle_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from next-state values so the registered copies line up with the state.
    ppm_nxt   = (state_nxt == SYMBOL) && ({3'b000, shreg_nxt[7:6]} == slot_nxt);
    start_nxt = (state_nxt == SYMBOL) && (slot_nxt == 5'd0) && (cyc_nxt == 8'd0);
    done_nxt  = (state_nxt == SYMBOL) && (sym_nxt == 2'd3) &&
                (slot_nxt == SLOT_LAST) && (cyc_nxt == CYC_LAST);
    busy_nxt  = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sym_cnt        <= 2'd0;
      slot_cnt       <= 5'd0;
      cyc_cnt        <= 8'd0;
      settle_cnt     <= 1'b0;
      ppm_out        <= 1'b0;
      sym_start      <= 1'b0;
      data_send_done <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      sym_cnt        <= sym_nxt;
      slot_cnt       <= slot_nxt;
      cyc_cnt        <= cyc_nxt;
      settle_cnt     <= settle_nxt;
      ppm_out        <= ppm_nxt;
      sym_start      <= start_nxt;
      data_send_done <= done_nxt;
      busy           <= busy_nxt;
    end
  end

  // Byte shift register is pure data; it is always reloaded in LOAD before use.
  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

endmodule

// File: doc/ppm_shift_two.md
# ppm_shift_two

4-PPM symbol modulator directly downstream of the PPM frame buffer. It consumes one byte at a time from the buffer's `data_out`/`shift_two_strobe` interface and splits each byte into four 2-bit symbols, MSB pair first. Each symbol is emitted on `ppm_out` as a single pulse placed in one of four time slots. When the last symbol of a byte completes, the block returns a one-cycle `data_send_done` pulse so the buffer can advance to the next byte.

## Interface
Parameters:
- `SLOT_CYCLES`, default 4: clock cycles per PPM slot; legal range 1..255.
- `GUARD_SLOTS`, default 0: empty slots appended after the 4 data slots of every symbol; legal range 0..15.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `strobe`  in  1  buffer has a valid byte on `data_in`; driven by the buffer's `shift_two_strobe`.
- `data_in`  in  8  byte to transmit; driven by the buffer's `data_out`.
- `data_send_done`  out  1  one-cycle pulse: current byte fully transmitted.
- `ppm_out`  out  1  PPM pulse line.
- `busy`  out  1  high in every state except IDLE.
- `sym_start`  out  1  one-cycle pulse on the first cycle of every symbol.

## Operation
- All state and outputs are registered. Reset value of every output is 0; the FSM resets to IDLE.
- States: IDLE, LOAD, SYMBOL, SETTLE.
- IDLE: if `strobe`=1, go to LOAD; otherwise stay.
- LOAD:
  - If `strobe`=1: latch `data_in` into an 8-bit shift register, clear the symbol counter (2 bits), slot counter (5 bits) and cycle counter (8 bits), and go to SYMBOL.
  - If `strobe`=0: go to IDLE; no pulse is produced.
- SYMBOL:
  - Current symbol value v = `shreg[7:6]`.
  - `ppm_out`=1 exactly while slot counter == v; 0 in all other data slots and in all guard slots.
  - The cycle counter wraps at `SLOT_CYCLES`-1 and then advances the slot counter.
  - The slot counter wraps at 3+`GUARD_SLOTS`. On that wrap, `shreg` shifts left by 2 and the symbol counter increments.
  - After the 4th symbol's last cycle: pulse `data_send_done` for exactly one cycle, then go to SETTLE.
- SETTLE: lasts exactly 2 cycles, then go to LOAD.
  - Required because the buffer decrements its count on the cycle it samples `data_send_done` and re-registers `data_out` one cycle later.
  - Sampling `data_in`/`strobe` earlier would read a stale byte.
- `strobe` falling during SYMBOL or SETTLE is ignored: the byte in flight completes and `data_send_done` still pulses. LOAD then sees `strobe`=0 and returns to IDLE.
- `data_send_done` is never high for more than one cycle; the buffer decrements once per high cycle.
- Reset mid-byte: `ppm_out` drops to 0 immediately (asynchronously) and the FSM returns to IDLE. No `data_send_done` is produced.

## Timing
- Symbol period: Ts = (4+`GUARD_SLOTS`)·`SLOT_CYCLES` cycles. Byte period: 4·Ts cycles in SYMBOL.
- Latency from IDLE: `strobe` rises at edge t; LOAD at t+1; first SYMBOL cycle (`sym_start`=1) at t+2.
- The pulse for v starts v·`SLOT_CYCLES` cycles after `sym_start` and lasts exactly `SLOT_CYCLES` cycles.
- `data_send_done` is asserted in the final SYMBOL cycle of the byte.
- Inter-byte gap: 3 cycles (SETTLE, SETTLE, LOAD) with `ppm_out`=0.
  - The next `sym_start` occurs 4 cycles after the cycle carrying `data_send_done`.
- Frame end: the buffer drops `strobe` 2 cycles after the last `data_send_done`. LOAD samples `strobe`=0 and the FSM is in IDLE, with `busy`=0, 4 cycles after the last `data_send_done`.
- With `SLOT_CYCLES`=1, slots are single cycles. Back-to-back symbols with v=3 then v=0 produce `ppm_out` high on 2 consecutive cycles; this is legal.

## Test plan
- Single byte 0xB4, `SLOT_CYCLES`=4, `GUARD_SLOTS`=0 -> symbols 2,3,1,0.
  - `ppm_out` high at cycle offsets 8–11, 28–31, 36–39 and 48–51 from the first `sym_start`.
  - One `data_send_done` at offset 63.
- Three-byte frame driven through a buffer model (decrement on done, `data_out` updated one cycle later) with bytes 0x00, 0xFF, 0x1B.
  - Expected symbols: 0,0,0,0 / 3,3,3,3 / 0,1,2,3, in that order.
  - Exactly 3 `data_send_done` pulses; no byte repeated or skipped.
- `GUARD_SLOTS`=2, `SLOT_CYCLES`=1, byte 0xE4:
  - Ts=6.
  - Pulses at offsets 3, 8, 13, 18.
  - Guard slots are low.
- Drop `strobe` mid-byte -> the byte completes, `data_send_done` pulses once, and `busy`=0 four cycles later with no further `sym_start`.
- Assert `rst_n`=0 during a pulse -> `ppm_out` and `busy` are 0 immediately, with no `data_send_done`. A new `strobe` restarts cleanly with `sym_start` 2 cycles later.
- `strobe` held low after reset for 100 cycles -> all outputs stay 0.
